// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory access controller.
package mem_pkg;

  localparam int unsigned WORD_AW_DEF = 10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_DATA  = 3'd2,
    WR       = 3'd3,
    RMW_RD   = 3'd4,
    RMW_WR   = 3'd5,
    ERR      = 3'd6
  } state_t;

  // Request fields captured on accept
  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/lsu_data_align.sv
// Load lane extraction/extension and store lane merge for sub-word accesses.
module lsu_data_align
  import mem_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'd0:    byte_sel = rd[7:0];
      2'd1:    byte_sel = rd[15:8];
      2'd2:    byte_sel = rd[23:16];
      default: byte_sel = rd[31:24];
    endcase
    half_sel = lane[1] ? rd[31:16] : rd[15:0];
  end

  // funct3[2] selects zero extension, funct3[1:0] selects size
  always_comb begin
    load_data = rd;
    case (funct3[1:0])
      2'b00:   load_data = funct3[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_data = funct3[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rd;
    endcase
  end

  always_comb begin
    merge_data = rd;
    case (funct3[1:0])
      2'b00: begin
        case (lane)
          2'd0:    merge_data[7:0]   = wdata[7:0];
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          default: merge_data[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) merge_data[31:16] = wdata[15:0];
        else         merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: validates requests, sequences memory strobes,
// performs read-modify-write for sub-word stores.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned WORD_AW = WORD_AW_DEF
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        store_done,
  output logic        access_err,
  output logic        MEMRead,
  output logic        MEMWrite,
  output logic [31:0] ADDR,
  output logic [31:0] WD,
  input  logic [31:0] RD
);

  state_t state, state_nxt;
  req_t   req_q;
  logic   req_err_c;
  logic   accept_c;
  logic [31:0] align_load_c;
  logic [31:0] align_merge_c;

  assign accept_c = req_valid && req_ready;

  // Request legality: size code, single direction, alignment, address range
  always_comb begin
    req_err_c = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: req_err_c = 1'b0;
      F3_H, F3_HU: req_err_c = req_addr[0];
      F3_W:        req_err_c = |req_addr[1:0];
      default:     req_err_c = 1'b1;
    endcase
    if (req_load == req_store) req_err_c = 1'b1;
    if ((req_addr >> (WORD_AW + 2)) != 32'd0) req_err_c = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (req_err_c)               state_nxt = ERR;
          else if (req_load)           state_nxt = RD_ISSUE;
          else if (req_funct3 == F3_W) state_nxt = WR;
          else                         state_nxt = RMW_RD;
        end
      end
      RD_ISSUE: state_nxt = RD_DATA;
      RMW_RD:   state_nxt = RMW_WR;
      default:  state_nxt = IDLE;
    endcase
  end

  // State, captured request and strobe outputs all derive from the next state
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_q      <= '0;
      req_ready  <= 1'b1;
      load_valid <= 1'b0;
      store_done <= 1'b0;
      access_err <= 1'b0;
      MEMRead    <= 1'b0;
      MEMWrite   <= 1'b0;
    end else begin
      state      <= state_nxt;
      if (accept_c) begin
        req_q.funct3 <= req_funct3;
        req_q.addr   <= req_addr;
        req_q.wdata  <= req_wdata;
      end
      req_ready  <= (state_nxt == IDLE);
      load_valid <= (state_nxt == RD_DATA);
      store_done <= (state_nxt == WR) || (state_nxt == RMW_WR);
      access_err <= (state_nxt == ERR);
      MEMRead    <= (state_nxt == RD_ISSUE) || (state_nxt == RMW_RD);
      MEMWrite   <= (state_nxt == WR) || (state_nxt == RMW_WR);
    end
  end

  lsu_data_align u_align (
    .rd         (RD),
    .lane       (req_q.addr[1:0]),
    .funct3     (req_q.funct3),
    .wdata      (req_q.wdata),
    .load_data  (align_load_c),
    .merge_data (align_merge_c)
  );

  // RD is only trustworthy in the cycle after a read, so gate it onto the outputs
  assign ADDR      = {req_q.addr[31:2], 2'b00};
  assign load_data = load_valid ? align_load_c : 32'd0;
  assign WD        = (state == WR)     ? req_q.wdata :
                     (state == RMW_WR) ? align_merge_c : 32'd0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a registered-read 1024-word memory.
module tb_mem_access_ctrl;

  logic        clk_50 = 1'b0;
  logic        rst_n;
  logic        req_valid, req_load, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, load_valid, store_done, access_err;
  logic [31:0] load_data;
  logic        MEMRead, MEMWrite;
  logic [31:0] ADDR, WD, RD;

  logic [31:0] mem [0:1023];
  logic [31:0] rd_q;
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;

  int vectors = 0;
  int miscompares = 0;

  always #10 clk_50 = ~clk_50;

  mem_access_ctrl dut (
    .clk_50     (clk_50),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_load   (req_load),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .load_valid (load_valid),
    .load_data  (load_data),
    .store_done (store_done),
    .access_err (access_err),
    .MEMRead    (MEMRead),
    .MEMWrite   (MEMWrite),
    .ADDR       (ADDR),
    .WD         (WD),
    .RD         (RD)
  );

  always @(posedge clk_50) begin
    if (pre_we)        mem[pre_idx] <= pre_data;
    else if (MEMWrite) mem[ADDR[11:2]] <= WD;
    if (MEMRead)       rd_q <= mem[ADDR[11:2]];
  end
  assign RD = rd_q;

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    tick();
    pre_we = 1'b0;
  endtask

  // Present a request for one edge then withdraw it
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_load = ld; req_store = st;
    req_funct3 = f3; req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, a, 32'd0);
    chk({tag, " rd_strobe"}, 32'(MEMRead), 32'd1);
    chk({tag, " addr"}, ADDR, {a[31:2], 2'b00});
    tick();
    chk({tag, " load_valid"}, 32'(load_valid), 32'd1);
    chk({tag, " load_data"}, load_data, exp);
    tick();
    chk({tag, " ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic do_rmw(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp);
    issue(1'b0, 1'b1, f3, a, wd);
    chk({tag, " rd_strobe"}, 32'({MEMRead, MEMWrite}), 32'd2);
    tick();
    chk({tag, " wr_strobe"}, 32'({MEMRead, MEMWrite, store_done}), 32'd3);
    chk({tag, " wd"}, WD, exp);
    tick();
    chk({tag, " mem"}, mem[a[11:2]], exp);
    chk({tag, " wd_idle"}, WD, 32'd0);
  endtask

  task automatic do_err(input string tag, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a);
    issue(ld, st, f3, a, 32'h1234_5678);
    chk({tag, " access_err"}, 32'(access_err), 32'd1);
    chk({tag, " no_strobes"}, 32'({MEMRead, MEMWrite, req_ready}), 32'd0);
    tick();
    chk({tag, " ready_back"}, 32'({req_ready, access_err}), 32'd2);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    pre_we = 1'b0; pre_idx = 10'd0; pre_data = 32'd0; rd_q = 32'd0;
    tick(); tick();
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset strobes", 32'({MEMRead, MEMWrite, load_valid, store_done, access_err}), 32'd0);
    chk("reset addr", ADDR, 32'd0);
    chk("reset wd", WD, 32'd0);
    chk("reset load_data", load_data, 32'd0);
    rst_n = 1'b1;
    preload(10'd1, 32'h8077_FF05);
    preload(10'd2, 32'd0);
    preload(10'd3, 32'd0);
    preload(10'd4, 32'h5566_7788);

    do_load("lw4",  3'b010, 32'h4, 32'h8077_FF05);
    do_load("lb7",  3'b000, 32'h7, 32'hFFFF_FF80);
    do_load("lbu7", 3'b100, 32'h7, 32'h0000_0080);
    do_load("lh6",  3'b001, 32'h6, 32'hFFFF_8077);
    do_load("lhu4", 3'b101, 32'h4, 32'h0000_FF05);
    do_load("lb4",  3'b000, 32'h4, 32'h0000_0005);

    preload(10'd1, 32'h1122_3344);
    do_rmw("sb5", 3'b000, 32'h5, 32'h0000_00AB, 32'h1122_AB44);
    preload(10'd1, 32'h1122_3344);
    do_rmw("sh6", 3'b001, 32'h6, 32'h0000_BEEF, 32'hBEEF_3344);

    do_err("err_lw2",   1'b1, 1'b0, 3'b010, 32'h2);
    do_err("err_sh3",   1'b0, 1'b1, 3'b001, 32'h3);
    do_err("err_f3",    1'b1, 1'b0, 3'b011, 32'h0);
    do_err("err_range", 1'b1, 1'b0, 3'b010, 32'h1000);
    do_err("err_both",  1'b1, 1'b1, 3'b010, 32'h4);

    // Word store, stray request while busy, then load in the next IDLE cycle
    issue(1'b0, 1'b1, 3'b010, 32'h8, 32'hCAFE_F00D);
    chk("sw wr_strobe", 32'({MEMRead, MEMWrite, store_done}), 32'd3);
    chk("sw wd", WD, 32'hCAFE_F00D);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'hC; req_wdata = 32'h1234_5678;
    tick();
    chk("b2b ready", 32'({req_ready, MEMWrite}), 32'd2);
    req_store = 1'b0; req_load = 1'b1; req_addr = 32'h8; req_wdata = 32'd0;
    tick();
    req_valid = 1'b0; req_load = 1'b0;
    chk("b2b rd_strobe", 32'({MEMRead, MEMWrite}), 32'd2);
    tick();
    chk("b2b load_data", load_data, 32'hCAFE_F00D);
    chk("b2b ignored", mem[3], 32'd0);
    tick();

    // Reset during RMW_RD must abandon the write
    issue(1'b0, 1'b1, 3'b000, 32'h10, 32'h0000_0099);
    chk("rst rmw_rd", 32'({MEMRead, MEMWrite}), 32'd2);
    rst_n = 1'b0;
    tick();
    chk("rst idle", 32'({req_ready, MEMRead, MEMWrite, store_done}), 32'd8);
    rst_n = 1'b1;
    tick();
    chk("rst no_write", 32'({MEMWrite, store_done, load_valid}), 32'd0);
    tick();
    chk("rst mem_kept", mem[4], 32'h5566_7788);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: WORD_AW, default 10, word-address width of the attached data memory (1024 words, 4 KiB).
REQ-002 clk_50 input 1: single clock; all state updates on rising edge.
REQ-003 rst_n input 1: reset is synchronous and active-low.
REQ-004 req_valid input 1: pipeline MEM-stage access request.
REQ-005 req_load input 1: request is a load.
REQ-006 req_store input 1: request is a store.
REQ-007 req_funct3 input 3: size code; 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 req_addr input 32: byte address.
REQ-009 req_wdata input 32: store data, right-aligned.
REQ-010 req_ready output 1: high exactly when state is IDLE; a request is accepted on an edge where req_valid and req_ready are both high.
REQ-011 load_valid output 1: one-cycle pulse; load_data is valid.
REQ-012 load_data output 32: extended load result.
REQ-013 store_done output 1: one-cycle pulse in the cycle MEMWrite is driven.
REQ-014 access_err output 1: one-cycle pulse; request rejected with no memory access.
REQ-015 MEMRead output 1: memory read strobe.
REQ-016 MEMWrite output 1: memory write strobe.
REQ-017 ADDR output 32: word-aligned address {addr[31:2],2'b00}.
REQ-018 WD output 32: memory write data.
REQ-019 RD input 32: memory read data; valid only in the cycle after a MEMRead cycle; otherwise undefined (may be Z).

Function
REQ-020 FSM states: IDLE, RD_ISSUE, RD_DATA, WR, RMW_RD, RMW_WR, ERR; every non-IDLE state lasts exactly one cycle.
REQ-021 On accept, the request is registered, so the pipeline need not hold its inputs.
REQ-022 Error conditions (any of these sends the FSM to ERR):
- illegal funct3 (011, 110, 111);
- both or neither of req_load/req_store;
- w misaligned (addr[1:0]!=0), or h/hu misaligned (addr[0]!=0);
- addr[31:WORD_AW+2] nonzero.
REQ-023 ERR: access_err=1 and no memory strobes; next state is IDLE.
REQ-024 Load path:
- Accept edge A leads to RD_ISSUE in cycle A+1 (MEMRead=1).
- RD_DATA follows in cycle A+2, with load_valid=1 and load_data extracted combinationally from RD and the registered addr[1:0].
- Then IDLE. Load latency is 2 cycles.
REQ-025 Load extraction:
- b/h are sign-extended; bu/hu are zero-extended.
- Byte lane = addr[1:0]; halfword lane = addr[1].
REQ-026 Word store: accept leads to WR in cycle A+1 (MEMWrite=1, WD=wdata, store_done=1), then IDLE.
REQ-027 Sub-word store (read-modify-write):
- RMW_RD in cycle A+1 (MEMRead=1).
- RMW_WR in cycle A+2: MEMWrite=1, store_done=1, WD=RD with the addressed byte/halfword lane replaced by wdata[7:0]/[15:0].
REQ-028 In every state other than those stated above, MEMRead=0 and MEMWrite=0; MEMRead and MEMWrite are never high together.
REQ-029 ADDR and WD are held from accept until IDLE; WD=0 outside write cycles.
REQ-030 req_valid while not ready is ignored; no queuing.
REQ-031 Back-to-back: an accept is allowed in the IDLE cycle immediately following the completion state.

Reset
REQ-032 On a clock edge with rst_n=0, the FSM shall be IDLE, all registered request fields 0, and all outputs 0 except req_ready=1.
REQ-033 Reset mid-operation abandons the access: no load_valid or store_done follows. A MEMWrite already high in the reset cycle lands in memory; RMW_RD aborted by reset issues no write.

Structure
REQ-034 Shared package mem_pkg holds:
- funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
- the FSM state encoding;
- WORD_AW default.
REQ-035 One combinational sub-module, lsu_data_align, performs load extraction/extension and store lane merge; the FSM lives in mem_access_ctrl.

Verification
REQ-036 The bench shall use a 1024-word memory model that registers RD one cycle after MEMRead.
REQ-037 Word load: word1=0x8077FF05, lw 0x4 -> MEMRead/ADDR=0x4 in A+1, load_valid with 0x8077FF05 in A+2.
REQ-038 Sub-word loads on the same word:
- lb 0x7 -> 0xFFFFFF80;
- lbu 0x7 -> 0x00000080;
- lh 0x6 -> 0xFFFF8077;
- lhu 0x4 -> 0x0000FF05.
REQ-039 RMW store: word1=0x11223344, sb 0xAB to 0x5 -> MEMRead A+1, MEMWrite+store_done in A+2 with WD=0x1122AB44; sh 0xBEEF to 0x6 -> WD=0xBEEF3344.
REQ-040 Errors: lw 0x2, sh 0x3, funct3=011, and addr 0x1000 each -> access_err in A+1, no MEMRead/MEMWrite, req_ready back high in A+2.
REQ-041 Back-to-back: sw 0xCAFEF00D to 0x8, then lw 0x8 accepted the next IDLE cycle -> load_data=0xCAFEF00D; a req_valid pulse during busy is ignored.
REQ-042 Reset: rst_n=0 in RMW_RD -> IDLE next cycle, MEMWrite never asserted, target word unchanged.
